// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types: RAM status, data word and coherence bus FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DWB,
        SNOOP,
        DRAM,
        C2C
    } bus_state_t;

endpackage

// File: rtl/coherence_bus_ctrl_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;
    int   cand;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Multicore memory bus controller with snooping coherence on data reads.
// Define CC_SNOOP_EN to build the SNOOP/C2C path; otherwise data reads go straight to RAM.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int WORDS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    input  logic [CPUS-1:0]     ccwrite,
    input  logic [CPUS-1:0]     cctrans,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]    iload,
    output word_t [CPUS-1:0]    dload,
    output logic [CPUS-1:0]     ccwait,
    output logic [CPUS-1:0]     ccinv,
    output word_t [CPUS-1:0]    ccsnoopaddr,
    input  ramstate_t           ramstate,
    input  word_t               ramload,
    output word_t               ramaddr,
    output word_t               ramstore,
    output logic                ramREN,
    output logic                ramWEN
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CW = $clog2(WORDS + 1);

    bus_state_t      state;
    logic [IW-1:0]   g, dptr, iptr, d_idx, i_idx;
    logic [CW-1:0]   cnt;
    logic [CPUS-1:0] d_req, d_grant, i_grant;
    logic            access, live, last;

    assign d_req  = dREN | dWEN;
    assign access = (ramstate == ACCESS);
    assign last   = (cnt == CW'(WORDS - 1));

    rr_arbiter #(.N(CPUS)) u_darb (.req(d_req), .ptr(dptr), .grant(d_grant), .idx(d_idx));
    rr_arbiter #(.N(CPUS)) u_iarb (.req(iREN),  .ptr(iptr), .grant(i_grant), .idx(i_idx));

`ifdef CC_SNOOP_EN
    logic [IW-1:0] s, sup_idx;
    logic          sup_found;

    // Descending scan so the lowest-numbered Modified holder ends up as supplier.
    always_comb begin
        sup_idx   = '0;
        sup_found = 1'b0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(g) && cctrans[j]) begin
                sup_found = 1'b1;
                sup_idx   = IW'(j);
            end
        end
    end
`else
    logic unused_cc;
    assign unused_cc = ^{cctrans, ccwrite};
`endif

    // The granted request is still asserted; dropping it aborts the transaction.
    always_comb begin
        live = 1'b1;
        case (state)
            IFETCH:  live = iREN[g];
            DWB:     live = dWEN[g];
            DRAM:    live = dREN[g];
`ifdef CC_SNOOP_EN
            C2C:     live = dREN[g];
`endif
            default: live = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            g     <= '0;
            cnt   <= '0;
            dptr  <= IW'(CPUS - 1);
            iptr  <= IW'(CPUS - 1);
`ifdef CC_SNOOP_EN
            s     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|d_grant) begin
                        g    <= d_idx;
                        dptr <= d_idx;
                        if (|(d_grant & dWEN)) state <= DWB;
`ifdef CC_SNOOP_EN
                        else                   state <= SNOOP;
`else
                        else                   state <= DRAM;
`endif
                    end else if (|i_grant) begin
                        g     <= i_idx;
                        iptr  <= i_idx;
                        state <= IFETCH;
                    end
                end
`ifdef CC_SNOOP_EN
                SNOOP: begin
                    if (sup_found) begin
                        s     <= sup_idx;
                        state <= C2C;
                    end else begin
                        state <= DRAM;
                    end
                end
                C2C,
`endif
                DWB, DRAM: begin
                    if (!live || (access && last)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (access) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IFETCH: begin
                    if (!live || access) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = {CPUS{ramload}};
        dload       = {CPUS{ramload}};
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramaddr     = '0;
        ramstore    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        case (state)
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g];
                if (access && live) iwait[g] = 1'b0;
            end
            DRAM: begin
                ramREN  = 1'b1;
                ramaddr = daddr[g];
                if (access && live) dwait[g] = 1'b0;
            end
            DWB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                if (access && live) dwait[g] = 1'b0;
            end
`ifdef CC_SNOOP_EN
            C2C: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[s];
                ramstore = dstore[s];
                dload[g] = dstore[s];
                if (access && live) begin
                    dwait[g] = 1'b0;
                    dwait[s] = 1'b0;
                end
            end
`endif
            default: ;
        endcase
`ifdef CC_SNOOP_EN
        if (state == SNOOP || state == C2C || state == DRAM) begin
            for (int j = 0; j < CPUS; j++) begin
                if (j != int'(g)) begin
                    ccwait[j]      = 1'b1;
                    ccsnoopaddr[j] = daddr[g];
                    ccinv[j]       = ccwrite[g];
                end
            end
        end
`endif
    end

endmodule
